jc_seq_ctrl: RTL and testbench
==============================

JC_SEQ_CTRL -- requirements
Module: jc_seq_ctrl

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h3000_0000: Wishbone base address; bits [3:0] are ignored.
REQ-002 SHALL have parameter QW, default 8: Johnson counter width; the only supported value is 8.
REQ-003 SHALL have port wb_clk_i, input, 1: the single clock; all logic is on the rising edge.
REQ-004 SHALL have port wb_rst_i, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have ports wbs_stb_i, wbs_cyc_i and wbs_we_i, each an input of width 1: Wishbone strobe, cycle and write enable.
REQ-006 SHALL have ports wbs_sel_i (input, 4), wbs_dat_i (input, 32) and wbs_adr_i (input, 32): byte selects, write data and address.
REQ-007 SHALL have ports wbs_ack_o (output, 1) and wbs_dat_o (output, 32): acknowledge and read data.
REQ-008 SHALL have port q_o, output, 8: Johnson counter state.
REQ-009 SHALL have port busy_o, output, 1: high while the FSM is in RUN.
REQ-010 SHALL have port irq_o, output, 1: done interrupt, level-sensitive.

Function
REQ-011 SHALL select the block when wbs_adr_i[31:4]==BASE_ADDR[31:4], with wbs_adr_i[3:2] choosing the register: 0 CTRL, 1 STEPS, 2 PRESCALE, 3 STATUS.
REQ-012 SHALL not acknowledge unselected addresses.
REQ-013 SHALL register wbs_ack_o high for exactly one cycle, one cycle after stb&cyc&select is seen with ack low.
REQ-014 SHALL commit writes on the edge that raises ack, honouring wbs_sel_i per byte; read data SHALL be valid while ack is high.
REQ-015 SHALL drive wbs_dat_o to 0 whenever ack is low.
REQ-016 SHALL implement CTRL as: [0] START pulse; [1] STOP pulse; [2] MODE (0 free-run, 1 counted); [3] DIR (0 up, 1 down); [4] CLR pulse; [5] IRQ_EN.
REQ-017 SHALL read the CTRL pulse bits (START, STOP, CLR) as 0.
REQ-018 SHALL implement STEPS as [15:0] step count for counted mode, and PRESCALE as [15:0], giving one tick every PRESCALE+1 cycles.
REQ-019 SHALL implement STATUS as: [7:0] q; [8] busy; [9] DONE, sticky, cleared by writing 1 to STATUS[9]; [31:16] remaining steps.
REQ-020 SHALL step the counter up as q <= {q[6:0], ~q[7]} and down as q <= {~q[0], q[7:1]}, giving a 16-state cycle.
REQ-021 SHALL implement FSM states IDLE, RUN and DONE.
REQ-022 SHALL transition IDLE->RUN on START, latching STEPS into remaining and PRESCALE into a working copy, and clearing the prescale counter.
REQ-023 SHALL transition IDLE->DONE on START when MODE=1 and STEPS=0, with no step taken.
REQ-024 SHALL, in RUN, advance q once per tick, with the first step exactly PRESCALE+1 cycles after the START commit edge.
REQ-025 SHALL, in counted mode, decrement remaining on each step, and go RUN->DONE on the step that makes remaining 0.
REQ-026 SHALL, in free-run mode, never exit RUN except on STOP; remaining holds its value.
REQ-027 SHALL go RUN->IDLE on STOP, holding q and leaving DONE unchanged.
REQ-028 SHALL go DONE->IDLE unconditionally after one cycle, setting the DONE sticky bit.
REQ-029 SHALL give STOP priority when START and STOP are written together, and SHALL ignore START while in RUN.
REQ-030 SHALL have CLR set q to 0 only in IDLE; CLR in RUN or DONE SHALL be ignored.
REQ-031 SHALL apply a DIR write during RUN at the next tick; STEPS and PRESCALE writes during RUN SHALL take effect only at the next START.
REQ-032 SHALL let a DONE clear and a DONE set on the same edge resolve to set.

Reset
REQ-033 SHALL, while wb_rst_i is sampled high, set: q=0; FSM=IDLE; all registers, remaining and prescale counter=0; wbs_ack_o=0; wbs_dat_o=0; busy_o=0; irq_o=0.
REQ-034 SHALL, when reset occurs mid-RUN or mid-transaction, abort the operation with no ack issued.

Configuration
REQ-035 SHALL, with JC_SEQ_CTRL_IRQ_EN defined, drive irq_o = DONE & IRQ_EN.
REQ-036 SHALL, without JC_SEQ_CTRL_IRQ_EN, tie irq_o to 0, read CTRL[5] as 0 and ignore writes to CTRL[5].

Structure
REQ-037 SHALL take the register offsets, the CTRL/STATUS bit positions and the FSM state enum from shared package jc_seq_pkg.
REQ-038 SHALL contain the counter datapath in sub-module jc_step_core (enable, dir, clr; q out); register file and FSM stay in jc_seq_ctrl.

Verification
REQ-039 SHALL verify reset: after reset, all outputs read 0, STATUS reads 0, and no ack occurs for an out-of-range address.
REQ-040 SHALL verify counted mode: PRESCALE=0, STEPS=5, MODE=1, DIR=0, START gives q=01,03,07,0F,1F on consecutive cycles, then DONE=1, busy=0 and remaining=0.
REQ-041 SHALL verify down stepping with prescale: PRESCALE=3, STEPS=2, DIR=1 from q=0 gives q=80 at START+4 and C0 at START+8.
REQ-042 SHALL verify free-run and STOP: MODE=0, PRESCALE=0, 20 cycles then STOP gives busy=0, q held and DONE=0; the q sequence wraps 00->FF->00 after 16 steps.
REQ-043 SHALL verify boundaries: STEPS=0 with START sets DONE next cycle with q unchanged; START+STOP together leaves the FSM in IDLE; CLR during RUN leaves q unchanged.
REQ-044 SHALL verify interrupt and byte enables: with JC_SEQ_CTRL_IRQ_EN and IRQ_EN=1, irq_o rises with DONE and falls after writing STATUS=0x200; a STEPS write 0x1234 with sel=4'b0001 changes only byte 0 of STEPS.

Source files
------------

// File: rtl/jc_seq_pkg.sv
// jc_seq_pkg: register offsets, CTRL/STATUS bit positions, FSM states and a byte-merge helper
package jc_seq_pkg;
    localparam logic [1:0] REG_CTRL     = 2'd0;
    localparam logic [1:0] REG_STEPS    = 2'd1;
    localparam logic [1:0] REG_PRESCALE = 2'd2;
    localparam logic [1:0] REG_STATUS   = 2'd3;
    localparam int CTRL_START  = 0;
    localparam int CTRL_STOP   = 1;
    localparam int CTRL_MODE   = 2;
    localparam int CTRL_DIR    = 3;
    localparam int CTRL_CLR    = 4;
    localparam int CTRL_IRQ_EN = 5;
    localparam int STATUS_BUSY = 8;
    localparam int STATUS_DONE = 9;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    function automatic logic [15:0] merge16(input logic [15:0] old, input logic [15:0] d, input logic [1:0] be);
        return {be[1] ? d[15:8] : old[15:8], be[0] ? d[7:0] : old[7:0]};
    endfunction
endpackage

// File: rtl/jc_step_core.sv
// jc_step_core: 8-bit Johnson counter datapath
// Ports: clk, rst (sync, active-high), en (take one step), dir (0 up, 1 down), clr (q to 0), q (state)
module jc_step_core (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       dir,
    input  logic       clr,
    output logic [7:0] q
);
    always_ff @(posedge clk) begin
        if (rst || clr) q <= '0;
        else if (en) q <= dir ? {~q[0], q[7:1]} : {q[6:0], ~q[7]};
    end
endmodule

// File: rtl/jc_seq_ctrl.sv
// jc_seq_ctrl: Wishbone-controlled Johnson counter sequencer (IDLE/RUN/DONE)
// Ports: wb_clk_i, wb_rst_i (sync, active-high); Wishbone slave wbs_*; q_o counter state;
// busy_o high in RUN; irq_o done interrupt (level), only live when JC_SEQ_CTRL_IRQ_EN is defined.
module jc_seq_ctrl
    import jc_seq_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          QW        = 8
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          wbs_stb_i,
    input  logic          wbs_cyc_i,
    input  logic          wbs_we_i,
    input  logic [3:0]    wbs_sel_i,
    input  logic [31:0]   wbs_dat_i,
    input  logic [31:0]   wbs_adr_i,
    output logic          wbs_ack_o,
    output logic [31:0]   wbs_dat_o,
    output logic [QW-1:0] q_o,
    output logic          busy_o,
    output logic          irq_o
);
    state_t state, state_d;
    logic [15:0] steps, prescale, remaining, pcnt, pwork;
    logic [31:0] rdata, ctrl_rd, stat_rd;
    logic [1:0] reg_sel;
    logic mode, dir, done, irq_en, req, wr, ctrl_wr, start_p, stop_p, clr_p, mode_n;
    logic done_clr, tick, step, launch, unused;
    assign reg_sel  = wbs_adr_i[3:2];
    assign req      = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]) & ~wbs_ack_o;
    assign wr       = req & wbs_we_i;
    assign ctrl_wr  = wr && reg_sel == REG_CTRL && wbs_sel_i[0];
    assign start_p  = ctrl_wr & wbs_dat_i[CTRL_START];
    assign stop_p   = ctrl_wr & wbs_dat_i[CTRL_STOP];
    assign clr_p    = ctrl_wr & wbs_dat_i[CTRL_CLR];
    // MODE written together with START must govern that START
    assign mode_n   = ctrl_wr ? wbs_dat_i[CTRL_MODE] : mode;
    assign done_clr = wr && reg_sel == REG_STATUS && wbs_sel_i[1] && wbs_dat_i[STATUS_DONE];
    assign tick     = pcnt == pwork;
    assign step     = state == S_RUN && tick && !stop_p;
    assign launch   = state == S_IDLE && start_p && !stop_p;
    assign busy_o   = state == S_RUN;
    assign unused   = ^{wbs_adr_i[1:0], wbs_dat_i[31:16], wbs_sel_i[3:2]};
    jc_step_core u_core (
        .clk (wb_clk_i),
        .rst (wb_rst_i),
        .en  (step),
        .dir (dir),
        .clr (clr_p && state == S_IDLE),
        .q   (q_o)
    );
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:  if (launch) state_d = (mode_n && steps == 16'd0) ? S_DONE : S_RUN;
            S_RUN:   if (stop_p) state_d = S_IDLE;
                     else if (step && mode && remaining <= 16'd1) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end
    always_comb begin
        ctrl_rd = '0;
        ctrl_rd[CTRL_MODE] = mode;
        ctrl_rd[CTRL_DIR] = dir;
        ctrl_rd[CTRL_IRQ_EN] = irq_en;
        stat_rd = {remaining, 16'd0};
        stat_rd[QW-1:0] = q_o;
        stat_rd[STATUS_BUSY] = busy_o;
        stat_rd[STATUS_DONE] = done;
        rdata = reg_sel == REG_CTRL ? ctrl_rd :
                reg_sel == REG_STEPS ? {16'd0, steps} :
                reg_sel == REG_PRESCALE ? {16'd0, prescale} : stat_rd;
    end
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state     <= S_IDLE;
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            steps     <= '0;
            prescale  <= '0;
            remaining <= '0;
            pcnt      <= '0;
            pwork     <= '0;
            mode      <= 1'b0;
            dir       <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_d;
            wbs_ack_o <= req;
            wbs_dat_o <= (req && !wbs_we_i) ? rdata : '0;
            if (ctrl_wr) begin
                mode <= wbs_dat_i[CTRL_MODE];
                dir  <= wbs_dat_i[CTRL_DIR];
            end
            if (wr && reg_sel == REG_STEPS) steps <= merge16(steps, wbs_dat_i[15:0], wbs_sel_i[1:0]);
            if (wr && reg_sel == REG_PRESCALE) prescale <= merge16(prescale, wbs_dat_i[15:0], wbs_sel_i[1:0]);
            // a set from leaving DONE wins over a software clear on the same edge
            done <= state == S_DONE || (done && !done_clr);
            if (launch) begin
                remaining <= steps;
                pwork     <= prescale;
                pcnt      <= '0;
            end else if (state == S_RUN) begin
                pcnt <= tick ? 16'd0 : pcnt + 16'd1;
                if (step && mode && remaining != 16'd0) remaining <= remaining - 16'd1;
            end
        end
    end
`ifdef JC_SEQ_CTRL_IRQ_EN
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) irq_en <= 1'b0;
        else if (ctrl_wr) irq_en <= wbs_dat_i[CTRL_IRQ_EN];
    end
    assign irq_o = done & irq_en;
`else
    assign irq_en = 1'b0;
    assign irq_o  = 1'b0;
`endif
endmodule

// File: tb/tb_jc_seq_ctrl.sv
// tb_jc_seq_ctrl: directed self-checking bench for jc_seq_ctrl
module tb_jc_seq_ctrl;
    logic clk = 0, rst = 1, stb = 0, cyc = 0, we = 0;
    logic [3:0] sel = '0;
    logic [31:0] dat_w = '0, adr = '0, dat_r, rd;
    logic ack, busy, irq;
    logic [7:0] q;
    int n_tests = 0, n_fail = 0;
    logic [7:0] up_seq [16] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                                8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};
`ifdef JC_SEQ_CTRL_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif
    jc_seq_ctrl dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_dat_i(dat_w), .wbs_adr_i(adr), .wbs_ack_o(ack), .wbs_dat_o(dat_r),
        .q_o(q), .busy_o(busy), .irq_o(irq)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic xfer(input logic w, input logic [1:0] r, input logic [31:0] d, input logic [3:0] s, output logic [31:0] rv);
        bit seen = 0;
        rv = 'x;
        @(negedge clk);
        adr = 32'h3000_0000 | {28'd0, r, 2'b00};
        stb = 1; cyc = 1; we = w; sel = s; dat_w = d;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(posedge clk); #1;
            if (ack) begin seen = 1; rv = dat_r; end
        end
        stb = 0; cyc = 0; we = 0;
        check("ack", {31'd0, seen}, 32'd1);
    endtask
    task automatic wr(input logic [1:0] r, input logic [31:0] d, input logic [3:0] s = 4'hF);
        logic [31:0] dummy;
        xfer(1'b1, r, d, s, dummy);
    endtask
    task automatic rd_chk(input string tag, input logic [1:0] r, input logic [31:0] exp);
        logic [31:0] v;
        xfer(1'b0, r, 32'd0, 4'hF, v);
        check(tag, v, exp);
    endtask
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    initial begin
        bit seen;
        // reset values and out-of-range address
        tick(3);
        check("rst_q", {24'd0, q}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_irq", {31'd0, irq}, 0);
        check("rst_ack", {31'd0, ack}, 0);
        check("rst_dat", dat_r, 0);
        @(negedge clk) rst = 0;
        rd_chk("rst_status", 2'd3, 32'h0);
        rd_chk("rst_ctrl", 2'd0, 32'h0);
        seen = 0;
        @(negedge clk);
        adr = 32'h3000_0010; stb = 1; cyc = 1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (ack) seen = 1;
        end
        stb = 0; cyc = 0;
        check("no_ack_oor", {31'd0, seen}, 0);
        // counted mode, prescale 0, 5 steps up
        wr(2'd2, 32'd0);
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h05);
        for (int k = 0; k < 5; k++) begin
            tick(1);
            check($sformatf("cnt_q%0d", k), {24'd0, q}, {24'd0, up_seq[k]});
            if (k == 0) check("cnt_busy", {31'd0, busy}, 1);
        end
        check("cnt_busy_end", {31'd0, busy}, 0);
        tick(1);
        rd_chk("cnt_status", 2'd3, 32'h0000_021F);
        // down stepping with prescale 3
        wr(2'd3, 32'h200, 4'b0010);
        rd_chk("done_clr", 2'd3, 32'h0000_001F);
        wr(2'd0, 32'h10);
        check("clr_idle", {24'd0, q}, 0);
        wr(2'd2, 32'd3);
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h0D);
        tick(3);
        check("dn_q3", {24'd0, q}, 32'h00);
        tick(1);
        check("dn_q4", {24'd0, q}, 32'h80);
        tick(3);
        check("dn_q7", {24'd0, q}, 32'h80);
        tick(1);
        check("dn_q8", {24'd0, q}, 32'hC0);
        tick(1);
        rd_chk("dn_status", 2'd3, 32'h0000_02C0);
        // free-run wrap, then STOP
        wr(2'd3, 32'h200, 4'b0010);
        wr(2'd0, 32'h10);
        wr(2'd2, 32'd0);
        wr(2'd0, 32'h01);
        for (int k = 0; k < 16; k++) begin
            tick(1);
            check($sformatf("fr_q%0d", k), {24'd0, q}, {24'd0, up_seq[k]});
        end
        tick(3);
        wr(2'd0, 32'h02);
        check("stop_busy", {31'd0, busy}, 0);
        check("stop_q", {24'd0, q}, 32'h07);
        tick(3);
        check("stop_hold", {24'd0, q}, 32'h07);
        rd_chk("stop_status", 2'd3, 32'h0002_0007);
        // STEPS=0 with START goes straight to DONE
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h05);
        check("z_busy", {31'd0, busy}, 0);
        check("z_q", {24'd0, q}, 32'h07);
        tick(1);
        rd_chk("z_status", 2'd3, 32'h0000_0207);
        wr(2'd3, 32'h200, 4'b0010);
        // START+STOP together: STOP wins
        wr(2'd0, 32'h07);
        check("ss_busy0", {31'd0, busy}, 0);
        tick(2);
        check("ss_busy2", {31'd0, busy}, 0);
        rd_chk("ss_status", 2'd3, 32'h0000_0007);
        // CLR during RUN is ignored, in IDLE clears
        wr(2'd2, 32'd100);
        wr(2'd0, 32'h01);
        check("cr_busy", {31'd0, busy}, 1);
        wr(2'd0, 32'h10);
        check("cr_q", {24'd0, q}, 32'h07);
        wr(2'd0, 32'h02);
        wr(2'd0, 32'h3C);
        check("ci_q", {24'd0, q}, 0);
        rd_chk("ctrl_rd", 2'd0, IRQ_ON ? 32'h2C : 32'h0C);
        tick(1);
        check("ack_one", {31'd0, ack}, 0);
        check("dat_idle", dat_r, 0);
        // interrupt
        wr(2'd2, 32'd0);
        wr(2'd1, 32'd1);
        wr(2'd0, 32'h25);
        tick(1);
        check("irq_pre", {31'd0, irq}, 0);
        check("irq_q", {24'd0, q}, 32'h01);
        tick(1);
        check("irq_set", {31'd0, irq}, {31'd0, IRQ_ON});
        wr(2'd3, 32'h200, 4'b0010);
        check("irq_clr", {31'd0, irq}, 0);
        // byte enables
        wr(2'd1, 32'hFFFF);
        wr(2'd1, 32'h1234, 4'b0001);
        rd_chk("steps_be", 2'd1, 32'h0000_FF34);
        wr(2'd2, 32'hABCD, 4'b0010);
        rd_chk("pre_be", 2'd2, 32'h0000_AB00);
        // reset mid-RUN and mid-transaction
        wr(2'd0, 32'h01);
        check("mr_busy", {31'd0, busy}, 1);
        @(negedge clk);
        rst = 1; adr = 32'h3000_000C; stb = 1; cyc = 1; we = 0;
        seen = 0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            if (ack) seen = 1;
        end
        check("mr_no_ack", {31'd0, seen}, 0);
        check("mr_busy0", {31'd0, busy}, 0);
        check("mr_q", {24'd0, q}, 0);
        @(negedge clk);
        rst = 0; stb = 0; cyc = 0;
        rd_chk("mr_status", 2'd3, 32'h0);
        rd_chk("mr_ctrl", 2'd0, 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
